// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: shares one single-port register bank between a posted
// SPI request FIFO and the TinyQV host req/ack bus, round-robin on contention.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   spi_valid/we/addr/wdata     posted SPI request (1-cycle pulse)
//   spi_rdata, spi_rvalid       SPI read result and its 1-cycle strobe
//   host_req/we/addr/wdata      host request, held until host_ack
//   host_ack, host_rdata        host completion pulse and read data
//   mem_en/we/addr/wdata        bank access (held when mem_en = 0)
//   mem_rdata                   bank read data, valid the cycle after a read
//   spi_overflow, ovf_clr       sticky dropped-request flag and its clear
//   busy                        access in flight or SPI requests queued
module spi_reg_arbiter #(
   parameter int ADDR_W     = 3,
   parameter int REG_W      = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_valid,
   input  logic              spi_we,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic [REG_W-1:0]  spi_wdata,
   output logic [REG_W-1:0]  spi_rdata,
   output logic              spi_rvalid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [REG_W-1:0]  host_wdata,
   output logic              host_ack,
   output logic [REG_W-1:0]  host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [REG_W-1:0]  mem_wdata,
   input  logic [REG_W-1:0]  mem_rdata,
   output logic              spi_overflow,
   input  logic              ovf_clr,
   output logic              busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + ADDR_W + REG_W;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_RDWAIT = 2'd2;

   logic [EW-1:0]     fifo_q [FIFO_DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [PW:0]       cnt_q, cnt_d;

   logic [1:0]        state_q, state_d;
   logic              last_spi_q, last_spi_d;
   logic              op_spi_q, op_spi_d;
   logic              op_we_q, op_we_d;
   logic [ADDR_W-1:0] op_addr_q, op_addr_d;
   logic [REG_W-1:0]  op_wdata_q, op_wdata_d;

   logic              host_ack_q, host_ack_d;
   logic [REG_W-1:0]  host_rdata_q, host_rdata_d;
   logic              spi_rvalid_q, spi_rvalid_d;
   logic [REG_W-1:0]  spi_rdata_q, spi_rdata_d;
   logic              ovf_q, ovf_d;

   logic              fifo_empty, fifo_full;
   logic              spi_cand, host_cand;
   logic              grant_spi, grant_host;
   logic              push, pop, drop;
   logic [EW-1:0]     head;

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == FULL_CNT);
   assign head       = fifo_q[rptr_q];

   // The ack cycle is not a request: the host has not yet seen it.
   assign spi_cand  = ~fifo_empty;
   assign host_cand = host_req & ~host_ack_q;

   always_comb begin
      grant_spi  = 1'b0;
      grant_host = 1'b0;
      if (state_q == S_IDLE) begin
         if (spi_cand && host_cand) begin
            grant_spi  = ~last_spi_q;
            grant_host = last_spi_q;
         end else begin
            grant_spi  = spi_cand;
            grant_host = host_cand;
         end
      end
   end

   // A full FIFO still accepts a push when it pops in the same cycle.
   assign pop  = grant_spi;
   assign push = spi_valid & (~fifo_full | pop);
   assign drop = spi_valid & fifo_full & ~pop;

   always_comb begin
      wptr_d = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_spi_d   = last_spi_q;
      op_spi_d     = op_spi_q;
      op_we_d      = op_we_q;
      op_addr_d    = op_addr_q;
      op_wdata_d   = op_wdata_q;
      host_ack_d   = 1'b0;
      host_rdata_d = host_rdata_q;
      spi_rvalid_d = 1'b0;
      spi_rdata_d  = spi_rdata_q;
      // Set wins over clear.
      ovf_d        = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

      case (state_q)
         S_IDLE: begin
            if (grant_spi) begin
               op_spi_d   = 1'b1;
               op_we_d    = head[EW-1];
               op_addr_d  = head[EW-2 -: ADDR_W];
               op_wdata_d = head[REG_W-1:0];
               last_spi_d = 1'b1;
               state_d    = S_ISSUE;
            end else if (grant_host) begin
               op_spi_d   = 1'b0;
               op_we_d    = host_we;
               op_addr_d  = host_addr;
               op_wdata_d = host_wdata;
               last_spi_d = 1'b0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (op_we_q) begin
               host_ack_d = ~op_spi_q;
               state_d    = S_IDLE;
            end else begin
               state_d    = S_RDWAIT;
            end
         end
         S_RDWAIT: begin
            if (op_spi_q) begin
               spi_rdata_d  = mem_rdata;
               spi_rvalid_d = 1'b1;
            end else begin
               host_rdata_d = mem_rdata;
               host_ack_d   = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= {spi_we, spi_addr, spi_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         cnt_q        <= '0;
         state_q      <= S_IDLE;
         last_spi_q   <= 1'b0;
         op_spi_q     <= 1'b0;
         op_we_q      <= 1'b0;
         op_addr_q    <= '0;
         op_wdata_q   <= '0;
         host_ack_q   <= 1'b0;
         host_rdata_q <= '0;
         spi_rvalid_q <= 1'b0;
         spi_rdata_q  <= '0;
         ovf_q        <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         last_spi_q   <= last_spi_d;
         op_spi_q     <= op_spi_d;
         op_we_q      <= op_we_d;
         op_addr_q    <= op_addr_d;
         op_wdata_q   <= op_wdata_d;
         host_ack_q   <= host_ack_d;
         host_rdata_q <= host_rdata_d;
         spi_rvalid_q <= spi_rvalid_d;
         spi_rdata_q  <= spi_rdata_d;
         ovf_q        <= ovf_d;
      end
   end

   assign mem_en       = (state_q == S_ISSUE);
   assign mem_we       = op_we_q;
   assign mem_addr     = op_addr_q;
   assign mem_wdata    = op_wdata_q;
   assign host_ack     = host_ack_q;
   assign host_rdata   = host_rdata_q;
   assign spi_rvalid   = spi_rvalid_q;
   assign spi_rdata    = spi_rdata_q;
   assign spi_overflow = ovf_q;
   assign busy         = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter: directed bench for spi_reg_arbiter with a
// registered-read bank model and a log of bank write addresses.
module tb_spi_reg_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_valid, spi_we;
   logic [2:0] spi_addr;
   logic [7:0] spi_wdata, spi_rdata;
   logic       spi_rvalid;
   logic       host_req, host_we, host_ack;
   logic [2:0] host_addr;
   logic [7:0] host_wdata, host_rdata;
   logic       mem_en, mem_we;
   logic [2:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       spi_overflow, ovf_clr, busy;

   logic [7:0] rd_val;
   logic [2:0] wa [64];
   int         wcnt = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         base;

   always #5 clk = ~clk;

   spi_reg_arbiter dut (
      .clk(clk), .rst(rst),
      .spi_valid(spi_valid), .spi_we(spi_we),
      .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid),
      .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .spi_overflow(spi_overflow), .ovf_clr(ovf_clr),
      .busy(busy)
   );

   // Bank model: registered read returning rd_val; logs write addresses.
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= rd_val;
      if (mem_en && mem_we) begin
         wa[wcnt[5:0]] <= mem_addr;
         wcnt <= wcnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      spi_valid = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      ovf_clr = 0; rd_val = 8'h00;
      tick(); tick();
      rst = 1'b0;
      check("rst_a", {spi_rdata, spi_rvalid, host_ack, host_rdata}, 0);
      check("rst_b", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      check("rst_c", {spi_overflow, busy}, 0);

      // Host write addr 3 = A5, grant in this cycle (T)
      host_req = 1; host_we = 1; host_addr = 3; host_wdata = 8'hA5;
      tick();
      check("hw_memen", {mem_en, mem_we}, 2'b11);
      check("hw_addr", mem_addr, 3);
      check("hw_wdata", mem_wdata, 8'hA5);
      check("hw_ack_t1", host_ack, 0);
      tick();
      check("hw_ack_t2", host_ack, 1);
      check("hw_memen_t2", mem_en, 0);
      host_req = 0;
      tick();
      check("hw_ack_t3", host_ack, 0);
      check("hw_busy", busy, 0);

      // SPI read addr 5, bank returns 3C
      rd_val = 8'h3C;
      spi_valid = 1; spi_we = 0; spi_addr = 5;
      tick();
      spi_valid = 0;
      check("sr_busy", busy, 1);
      tick();
      check("sr_memen", {mem_en, mem_we}, 2'b10);
      check("sr_addr", mem_addr, 5);
      tick();
      check("sr_rv_t2", spi_rvalid, 0);
      tick();
      check("sr_rv_t3", spi_rvalid, 1);
      check("sr_rdata", spi_rdata, 8'h3C);
      check("sr_noack", host_ack, 0);
      tick();
      check("sr_rv_t4", spi_rvalid, 0);
      check("sr_hold", spi_rdata, 8'h3C);

      // Round-robin after reset: SPI, HOST, SPI, HOST, SPI
      rst = 1; tick(); rst = 0;
      spi_valid = 1; spi_we = 1; spi_addr = 2; spi_wdata = 8'h22;
      tick();
      // Both candidates present in this IDLE cycle
      spi_addr = 4; spi_wdata = 8'h44;
      host_req = 1; host_we = 1; host_addr = 1; host_wdata = 8'h11;
      tick();
      spi_valid = 0;
      check("rr_g1_addr", {mem_en, mem_addr}, {1'b1, 3'd2});
      check("rr_g1_data", mem_wdata, 8'h22);
      tick();
      spi_valid = 1; spi_addr = 7; spi_wdata = 8'h77;
      tick();
      spi_valid = 0;
      check("rr_g2_addr", {mem_en, mem_addr}, {1'b1, 3'd1});
      check("rr_g2_data", mem_wdata, 8'h11);
      tick();
      check("rr_ack1", host_ack, 1);
      host_addr = 6; host_wdata = 8'h66;
      tick();
      check("rr_g3_addr", {mem_en, mem_addr}, {1'b1, 3'd4});
      tick();
      tick();
      check("rr_g4_addr", {mem_en, mem_addr}, {1'b1, 3'd6});
      tick();
      check("rr_ack2", host_ack, 1);
      host_req = 0;
      tick();
      check("rr_g5_addr", {mem_en, mem_addr}, {1'b1, 3'd7});
      tick(); tick();
      check("rr_idle", busy, 0);

      // Six back-to-back SPI writes into a 2-deep FIFO
      base = wcnt;
      for (int i = 0; i < 6; i++) begin
         spi_valid = 1; spi_we = 1;
         spi_addr = 3'(i); spi_wdata = 8'(8'h10 + i);
         tick();
      end
      spi_valid = 0;
      check("ov_flag", spi_overflow, 1);
      repeat (12) tick();
      check("ov_count", wcnt - base, 5);
      check("ov_w0", wa[6'(base + 0)], 0);
      check("ov_w1", wa[6'(base + 1)], 1);
      check("ov_w2", wa[6'(base + 2)], 2);
      check("ov_w3", wa[6'(base + 3)], 3);
      check("ov_w4", wa[6'(base + 4)], 5);
      check("ov_sticky", spi_overflow, 1);
      ovf_clr = 1;
      tick();
      ovf_clr = 0;
      check("ov_clr", spi_overflow, 0);

      // Host read: ack and data in T+3
      rd_val = 8'h5A;
      host_req = 1; host_we = 0; host_addr = 6;
      tick();
      check("hr_memen", {mem_en, mem_we}, 2'b10);
      tick();
      check("hr_ack_t2", host_ack, 0);
      tick();
      check("hr_ack_t3", host_ack, 1);
      check("hr_rdata", host_rdata, 8'h5A);
      host_req = 0;
      tick();

      // Reset during RDWAIT of a host read, SPI write queued
      rd_val = 8'h77;
      host_req = 1; host_we = 0; host_addr = 2;
      spi_valid = 1; spi_we = 1; spi_addr = 0; spi_wdata = 8'hEE;
      tick();
      spi_valid = 0;
      tick();
      check("ra_busy", busy, 1);
      rst = 1;
      tick();
      rst = 0; host_req = 0;
      check("ra_out_a", {spi_rdata, spi_rvalid, host_ack, host_rdata}, 0);
      check("ra_out_b", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
      check("ra_out_c", {spi_overflow, busy}, 0);
      base = wcnt;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ra_quiet", {host_ack, mem_en, busy}, 0);
      end
      check("ra_nowrite", wcnt - base, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
